// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller; load hits done in N+1, misses/stores one cycle after mem done.
// Optional hit/miss counters behind DCACHE_STATS_EN. Core holds i_en until o_done; memory requests held until i_mem_done.
module dcache_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_addr,
  input  logic              i_en,
  input  logic              i_rd_wr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_done
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       o_hit_cnt,
  output logic [31:0]       o_miss_cnt
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MEM_RD = 2'd1;
  localparam logic [1:0] S_MEM_WR = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              hit_q, hit_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [LINES-1:0]  valid_q, valid_d;

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  logic [INDEX_BITS-1:0] in_index, req_index;
  logic [TAG_W-1:0]      in_tag, req_tag;
  logic                  in_hit;

  logic              line_we;
  logic              line_set_tag;
  logic [DATA_W-1:0] line_wdata;
  logic              hit_inc;
  logic              miss_inc;

  // Core address bits above the memory width and the byte offset are don't-care.
  logic unused_addr;
  assign unused_addr = ^{i_addr[31:ADDR_W], i_addr[1:0]};

  assign in_index  = i_addr[INDEX_BITS+1:2];
  assign in_tag    = i_addr[ADDR_W-1:INDEX_BITS+2];
  assign req_index = addr_q[INDEX_BITS+1:2];
  assign req_tag   = addr_q[ADDR_W-1:INDEX_BITS+2];
  assign in_hit    = valid_q[in_index] && (tag_q[in_index] == in_tag);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    hit_d        = hit_q;
    rdata_d      = rdata_q;
    line_we      = 1'b0;
    line_set_tag = 1'b0;
    line_wdata   = '0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_en) begin
          addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
          wdata_d = i_wdata;
          hit_d   = in_hit;
          if (i_rd_wr) begin
            state_d = S_MEM_WR;
          end else if (in_hit) begin
            rdata_d = data_q[in_index];
            hit_inc = 1'b1;
            state_d = S_RESP;
          end else begin
            miss_inc = 1'b1;
            state_d  = S_MEM_RD;
          end
        end
      end
      S_MEM_RD: begin
        if (i_mem_done) begin
          line_we      = 1'b1;
          line_set_tag = 1'b1;
          line_wdata   = i_mem_rdata;
          rdata_d      = i_mem_rdata;
          state_d      = S_RESP;
        end
      end
      S_MEM_WR: begin
        // Write-through: only refresh the line if it was ours when the store was accepted.
        if (i_mem_done) begin
          line_we    = hit_q;
          line_wdata = wdata_q;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (line_we && line_set_tag) begin
      valid_d[req_index] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  // Tag/data arrays carry no reset; valid_q gates their use.
  always_ff @(posedge i_clk) begin
    if (line_we) begin
      data_q[req_index] <= line_wdata;
      if (line_set_tag) begin
        tag_q[req_index] <= req_tag;
      end
    end
  end

  assign o_rdata     = rdata_q;
  assign o_done      = (state_q == S_RESP);
  assign o_mem_rd    = (state_q == S_MEM_RD);
  assign o_mem_wr    = (state_q == S_MEM_WR);
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_inc && (hit_cnt_q != 32'hFFFF_FFFF)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (miss_inc && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = hit_inc ^ miss_inc;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: table of core requests with a variable-latency memory responder.
module tb_dcache_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_addr;
  logic        i_en;
  logic        i_rd_wr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_done;
  logic [15:0] o_mem_addr;
  logic        o_mem_rd;
  logic        o_mem_wr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_done;
`ifdef DCACHE_STATS_EN
  logic [31:0] o_hit_cnt;
  logic [31:0] o_miss_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  dcache_ctrl dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_addr      (i_addr),
    .i_en        (i_en),
    .i_rd_wr     (i_rd_wr),
    .i_wdata     (i_wdata),
    .o_rdata     (o_rdata),
    .o_done      (o_done),
    .o_mem_addr  (o_mem_addr),
    .o_mem_rd    (o_mem_rd),
    .o_mem_wr    (o_mem_wr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_done  (i_mem_done)
`ifdef DCACHE_STATS_EN
    ,
    .o_hit_cnt   (o_hit_cnt),
    .o_miss_cnt  (o_miss_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] wd;
    int          lat;
    logic [31:0] mrd;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issues one request, plays memory with the given latency, and returns what was observed.
  task automatic do_req(input logic [31:0] addr, input logic rw, input logic [31:0] wd,
                        input int lat, input logic [31:0] mrd,
                        output int latency, output int rd_cyc, output int wr_cyc,
                        output logic [15:0] maddr, output logic [31:0] mwd,
                        output logic [31:0] rdata, output bit both, output bit timeout);
    bit finished;
    latency  = 0;
    rd_cyc   = 0;
    wr_cyc   = 0;
    maddr    = '0;
    mwd      = '0;
    rdata    = '0;
    both     = 1'b0;
    timeout  = 1'b0;
    finished = 1'b0;
    i_addr   = addr;
    i_rd_wr  = rw;
    i_wdata  = wd;
    i_en     = 1'b1;
    while (!finished && !timeout) begin
      @(posedge i_clk);
      #1;
      latency++;
      i_mem_done = 1'b0;
      if (o_mem_rd && o_mem_wr) both = 1'b1;
      if (o_mem_rd || o_mem_wr) begin
        if (o_mem_rd) rd_cyc++;
        else wr_cyc++;
        maddr = o_mem_addr;
        mwd   = o_mem_wdata;
        if (rd_cyc + wr_cyc == lat) begin
          i_mem_done  = 1'b1;
          i_mem_rdata = mrd;
        end
      end
      if (o_done) begin
        rdata    = o_rdata;
        finished = 1'b1;
      end
      if (latency > 50) timeout = 1'b1;
    end
    i_en       = 1'b0;
    i_mem_done = 1'b0;
    @(posedge i_clk);
    #1;
    chk("done_single_cycle", {31'd0, o_done}, 32'd0);
  endtask

  int          latency, rd_cyc, wr_cyc;
  logic [15:0] maddr;
  logic [31:0] mwd, rdata;
  bit          both, timeout;
  int          exp_hits, exp_misses;
  logic [31:0] exp_maddr;

  initial begin
    vecs[0]  = '{32'h0000_0040, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, 4, 3, 0, 32'hDEAD_BEEF};
    vecs[1]  = '{32'h0000_0040, 1'b0, 32'h0, 1, 32'h0,         1, 0, 0, 32'hDEAD_BEEF};
    vecs[2]  = '{32'h0000_0040, 1'b1, 32'h1234_5678, 2, 32'h0, 3, 0, 2, 32'h0};
    vecs[3]  = '{32'h0000_0040, 1'b0, 32'h0, 1, 32'h0,         1, 0, 0, 32'h1234_5678};
    vecs[4]  = '{32'h0000_0140, 1'b0, 32'h0, 1, 32'hCAFE_0001, 2, 1, 0, 32'hCAFE_0001};
    vecs[5]  = '{32'h0000_0040, 1'b1, 32'hAAAA_AAAA, 1, 32'h0, 2, 0, 1, 32'h0};
    vecs[6]  = '{32'h0000_0140, 1'b0, 32'h0, 1, 32'h0,         1, 0, 0, 32'hCAFE_0001};
    vecs[7]  = '{32'h0000_0040, 1'b0, 32'h0, 2, 32'h1111_2222, 3, 2, 0, 32'h1111_2222};
    vecs[8]  = '{32'h0000_0040, 1'b1, 32'h0000_0055, 1, 32'h0, 2, 0, 1, 32'h0};
    vecs[9]  = '{32'h0000_0040, 1'b0, 32'h0, 1, 32'h0,         1, 0, 0, 32'h0000_0055};
    vecs[10] = '{32'h0000_0043, 1'b0, 32'h0, 1, 32'h0,         1, 0, 0, 32'h0000_0055};
    vecs[11] = '{32'h0001_0040, 1'b0, 32'h0, 1, 32'h0,         1, 0, 0, 32'h0000_0055};

    i_rst       = 1'b1;
    i_addr      = '0;
    i_en        = 1'b0;
    i_rd_wr     = 1'b0;
    i_wdata     = '0;
    i_mem_rdata = '0;
    i_mem_done  = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_done",      {31'd0, o_done},   32'd0);
    chk("rst_mem_rd",    {31'd0, o_mem_rd}, 32'd0);
    chk("rst_mem_wr",    {31'd0, o_mem_wr}, 32'd0);
    chk("rst_rdata",     o_rdata,           32'd0);
    chk("rst_mem_addr",  {16'd0, o_mem_addr}, 32'd0);
    chk("rst_mem_wdata", o_mem_wdata,       32'd0);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // A stray memory completion while idle must not produce a response.
    i_mem_done = 1'b1;
    @(posedge i_clk);
    #1;
    i_mem_done = 1'b0;
    chk("idle_memdone_no_done", {31'd0, o_done},   32'd0);
    chk("idle_memdone_no_rd",   {31'd0, o_mem_rd}, 32'd0);
    @(posedge i_clk);
    #1;

    exp_hits   = 0;
    exp_misses = 0;
    for (int v = 0; v < 12; v++) begin
      do_req(vecs[v].addr, vecs[v].rw, vecs[v].wd, vecs[v].lat, vecs[v].mrd,
             latency, rd_cyc, wr_cyc, maddr, mwd, rdata, both, timeout);
      chk($sformatf("v%0d_timeout", v), {31'd0, timeout}, 32'd0);
      chk($sformatf("v%0d_latency", v), latency, vecs[v].exp_lat);
      chk($sformatf("v%0d_rd_cycles", v), rd_cyc, vecs[v].exp_rd);
      chk($sformatf("v%0d_wr_cycles", v), wr_cyc, vecs[v].exp_wr);
      chk($sformatf("v%0d_rd_wr_overlap", v), {31'd0, both}, 32'd0);
      if (vecs[v].exp_rd + vecs[v].exp_wr > 0) begin
        exp_maddr = vecs[v].addr & 32'h0000_FFFC;
        chk($sformatf("v%0d_mem_addr", v), {16'd0, maddr}, exp_maddr);
      end
      if (vecs[v].rw) begin
        chk($sformatf("v%0d_mem_wdata", v), mwd, vecs[v].wd);
      end else begin
        chk($sformatf("v%0d_rdata", v), rdata, vecs[v].exp_rdata);
        if (vecs[v].exp_rd > 0) exp_misses++;
        else exp_hits++;
      end
    end

`ifdef DCACHE_STATS_EN
    chk("stats_hits",   o_hit_cnt,  exp_hits);
    chk("stats_misses", o_miss_cnt, exp_misses);
`endif

    // Reset in the middle of a miss: request drops at once and the line stays invalid.
    i_addr  = 32'h0000_0080;
    i_rd_wr = 1'b0;
    i_en    = 1'b1;
    @(posedge i_clk);
    #1;
    chk("midrst_rd_before", {31'd0, o_mem_rd}, 32'd1);
    @(posedge i_clk);
    #1;
    i_rst       = 1'b1;
    i_mem_done  = 1'b1;
    i_mem_rdata = 32'h9999_9999;
    #1;
    chk("midrst_rd_dropped", {31'd0, o_mem_rd}, 32'd0);
    chk("midrst_wr_low",     {31'd0, o_mem_wr}, 32'd0);
    i_en = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst      = 1'b0;
    i_mem_done = 1'b0;
    chk("midrst_no_done", {31'd0, o_done}, 32'd0);
    @(posedge i_clk);
    #1;
    chk("midrst_idle_no_done", {31'd0, o_done}, 32'd0);

    do_req(32'h0000_0080, 1'b0, 32'h0, 1, 32'h7777_0000,
           latency, rd_cyc, wr_cyc, maddr, mwd, rdata, both, timeout);
    chk("postrst_0x80_miss",  rd_cyc, 1);
    chk("postrst_0x80_rdata", rdata, 32'h7777_0000);
    chk("postrst_0x80_lat",   latency, 2);

    do_req(32'h0000_0140, 1'b0, 32'h0, 2, 32'h5151_5151,
           latency, rd_cyc, wr_cyc, maddr, mwd, rdata, both, timeout);
    chk("postrst_0x140_miss",  rd_cyc, 2);
    chk("postrst_0x140_rdata", rdata, 32'h5151_5151);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache controller. It sits between the core's data-memory port and the variable-latency backing data memory. It converts single-word core loads and stores into multi-cycle memory transactions, and serves load hits from on-chip tag/data arrays. It returns a one-cycle done pulse to the core for every accepted request.

Parameters:
ADDR_W, 16, address width presented to backing memory (core address truncated to this)
DATA_W, 32, word width
INDEX_BITS, 6, line index width (2**INDEX_BITS one-word lines)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_addr  in  32  core byte address; bits [1:0] ignored
i_en  in  1  core request valid; held with addr/rd_wr/wdata stable until o_done
i_rd_wr  in  1  1=store, 0=load
i_wdata  in  DATA_W  store data
o_rdata  out  DATA_W  load data, valid only while o_done=1
o_done  out  1  one-cycle completion pulse to core
o_mem_addr  out  ADDR_W  backing memory address (i_addr[ADDR_W-1:0], low 2 bits forced 0)
o_mem_rd  out  1  memory read request, held until i_mem_done
o_mem_wr  out  1  memory write request, held until i_mem_done
o_mem_wdata  out  DATA_W  memory write data
i_mem_rdata  in  DATA_W  memory read data, valid with i_mem_done
i_mem_done  in  1  memory transaction complete (one cycle)

Behaviour:
- Fields: index = i_addr[INDEX_BITS+1:2]; tag = i_addr[ADDR_W-1:INDEX_BITS+2]. Arrays: valid bit, tag and data per line.
- Reset (async, i_rst=1): all valid bits 0; state IDLE; o_done, o_mem_rd, o_mem_wr = 0; o_rdata, o_mem_addr, o_mem_wdata = 0. Tag/data array contents need not reset.
- FSM states: IDLE, MEM_RD, MEM_WR, RESP.
- IDLE: if i_en=0, stay in IDLE. Otherwise capture addr, rd_wr and wdata into request registers, then:
  - Load hit (valid && tag match): latch line data into o_rdata; next state RESP.
  - Load miss: next state MEM_RD.
  - Store (hit or miss): next state MEM_WR.
- MEM_RD: o_mem_rd=1 and o_mem_addr = captured address.
  - On i_mem_done: write i_mem_rdata into the line, set valid, write the tag, latch o_rdata = i_mem_rdata; next state RESP.
- MEM_WR: o_mem_wr=1, o_mem_wdata = captured wdata.
  - On i_mem_done: if the captured address hit at accept time, update the line data (tag and valid unchanged); a miss leaves the arrays untouched. Next state RESP.
- RESP: o_done=1 for exactly one cycle; i_en ignored; next state IDLE.
- Latency, with the request first seen in cycle N:
  - Load hit: o_done in N+1.
  - Miss or store: o_done one cycle after the i_mem_done cycle.
- Back-to-back: the next request may be accepted in the IDLE cycle that follows RESP, so the minimum spacing for load hits is 2 cycles.
- i_mem_done while in IDLE or RESP is ignored.
- o_mem_rd and o_mem_wr are never high together.
- Reset mid-transaction: the FSM aborts to IDLE, memory requests drop immediately, and no array update occurs.
- Collision: a store to the same index as a valid line with a different tag does not evict or modify that line.

Optional Feature:
DCACHE_STATS_EN:
- Defined: adds output ports o_hit_cnt [31:0] and o_miss_cnt [31:0], both reset to 0.
  - o_hit_cnt increments on every load hit accepted in IDLE.
  - o_miss_cnt increments on every load miss accepted in IDLE.
  - Stores are not counted.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load 0x0000_0040 after reset; memory returns 0xDEAD_BEEF after 3 cycles -> o_mem_rd held 3 cycles, o_done one cycle after i_mem_done, o_rdata=0xDEAD_BEEF.
- Repeat the load of 0x40 -> no o_mem_rd; o_done in N+1 with 0xDEAD_BEEF.
- Store 0x1234_5678 to 0x40, then load 0x40 -> o_mem_wr with o_mem_wdata=0x1234_5678; the load hits and returns 0x1234_5678 with no memory read.
- Load 0x140 (same index as 0x40, different tag), then store 0xAAAA_AAAA to 0x40, then load 0x140 -> the store does not alter the 0x140 line; the load hits with the original data.
- Assert i_rst during MEM_RD -> o_mem_rd=0 immediately; FSM in IDLE; a subsequent load of the same address misses.
- With DCACHE_STATS_EN defined: miss, hit, hit, store sequence -> o_hit_cnt=2, o_miss_cnt=1.
